// File: rtl/fwpayload_gpio_wb.sv
// Wishbone GPIO slave: pad out/oeb registers, synchronised inputs, rising-edge latch with level irq.
// Latency: ack and read data one cycle after the request is taken; pad rise to EDGE bit in 3 edges.
// Backpressure: none; one access per two cycles, ack never stalls, off-window addresses are never acked.
module fwpayload_gpio_wb #(
  parameter int          N_IO      = 38,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ID_VAL    = 32'h4750_494F
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [N_IO-1:0] io_in,
  output logic [N_IO-1:0] io_out,
  output logic [N_IO-1:0] io_oeb,
  output logic            irq_o
);

  logic [N_IO-1:0] out_q, oeb_q, ien_q, edge_q;
  logic [N_IO-1:0] sync1_q, sync2_q, hist_q;

  logic            hit, take;
  logic [5:0]      word;
  logic [31:0]     bmask;
  logic [N_IO-1:0] wmask, wdat, edge_clr, edge_nxt;
  logic [63:0]     out_x, oeb_x, in_x, edge_x, ien_x;
  logic [31:0]     rd_dat;
  logic            wr_out, wr_oeb, wr_ien, wr_edge;
  logic            unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  assign hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign take = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
  assign word = wbs_adr_i[7:2];

  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  // Odd words are the HI halves; truncation drops HI bits beyond N_IO.
  assign wmask = N_IO'(word[0] ? {bmask, 32'h0} : {32'h0, bmask});
  assign wdat  = N_IO'({wbs_dat_i, wbs_dat_i});

  assign wr_out  = take & wbs_we_i & (word[5:1] == 5'd0);
  assign wr_oeb  = take & wbs_we_i & (word[5:1] == 5'd1);
  assign wr_edge = take & wbs_we_i & (word[5:1] == 5'd3);
  assign wr_ien  = take & wbs_we_i & (word[5:1] == 5'd4);

  // Clear is applied before the OR so a coincident rise survives.
  assign edge_clr = wr_edge ? (wdat & wmask) : '0;
  assign edge_nxt = (edge_q & ~edge_clr) | (sync2_q & ~hist_q);

  assign out_x  = 64'(out_q);
  assign oeb_x  = 64'(oeb_q);
  assign in_x   = 64'(sync2_q);
  assign edge_x = 64'(edge_q);
  assign ien_x  = 64'(ien_q);

  always_comb begin
    rd_dat = '0;
    case (word)
      6'd0:    rd_dat = out_x[31:0];
      6'd1:    rd_dat = out_x[63:32];
      6'd2:    rd_dat = oeb_x[31:0];
      6'd3:    rd_dat = oeb_x[63:32];
      6'd4:    rd_dat = in_x[31:0];
      6'd5:    rd_dat = in_x[63:32];
      6'd6:    rd_dat = edge_x[31:0];
      6'd7:    rd_dat = edge_x[63:32];
      6'd8:    rd_dat = ien_x[31:0];
      6'd9:    rd_dat = ien_x[63:32];
      6'd10:   rd_dat = ID_VAL;
      default: rd_dat = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      out_q     <= '0;
      oeb_q     <= '1;
      ien_q     <= '0;
      edge_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      hist_q    <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_o     <= 1'b0;
    end else begin
      sync1_q   <= io_in;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      edge_q    <= edge_nxt;
      irq_o     <= |(edge_q & ien_q);
      wbs_ack_o <= take;
      if (take) wbs_dat_o <= rd_dat;
      if (wr_out) out_q <= (out_q & ~wmask) | (wdat & wmask);
      if (wr_oeb) oeb_q <= (oeb_q & ~wmask) | (wdat & wmask);
      if (wr_ien) ien_q <= (ien_q & ~wmask) | (wdat & wmask);
    end
  end

  assign io_out = out_q;
  assign io_oeb = oeb_q;

endmodule
